pwm_multi_channel: RTL and testbench
====================================

PWM_MULTI_CHANNEL -- requirements
Module: pwm_multi_channel

Interface
REQ-001 Parameter NUM_CH, default 16: number of PWM channels (1..32).
REQ-002 Parameter CNT_W, default 8: period counter and duty width (4..16).
REQ-003 Parameter ADDR_W, default $clog2(2*NUM_CH+1): register address width.
REQ-004 clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 wr_en  input  1  register write strobe, one write per cycle.
REQ-007 wr_addr  input  ADDR_W  write address.
REQ-008 wr_data  input  CNT_W  write data.
REQ-009 rd_addr  input  ADDR_W  read address, sampled every cycle.
REQ-010 rd_data  output  CNT_W  registered read data.
REQ-011 out  output  NUM_CH  registered PWM outputs, bit i = channel i.
REQ-012 period_start  output  1  one-cycle pulse on the cycle the period counter wraps to 0.

Function
REQ-013 Register map: addr 2i = DUTY_SHADOW[i] (CNT_W bits); addr 2i+1 = CTRL[i] (bit0 OUT_EN, bit1 PWM_EN, bit2 INVERT, other bits read 0); addr 2*NUM_CH = PRESC (CNT_W bits).
REQ-014 Writes to unmapped addresses SHALL be ignored; reads of unmapped addresses SHALL return 0.
REQ-015 rd_data SHALL present the register at rd_addr one cycle after rd_addr is sampled; DUTY reads return the shadow value.
REQ-016 Prescaler: counter pcnt counts 0..PRESC and wraps; tick SHALL be asserted in the cycle pcnt==PRESC; PRESC=0 gives a tick every cycle.
REQ-017 A write to PRESC SHALL clear pcnt to 0 in the same edge.
REQ-018 Period counter cnt SHALL advance by 1 on each tick over 0..MAX-1, MAX = 2^CNT_W-1, and wrap to 0; period = MAX ticks.
REQ-019 period_start SHALL be 1 in the cycle after the edge at which cnt wraps from MAX-1 to 0.
REQ-020 Each channel SHALL hold DUTY_ACTIVE[i], loaded from DUTY_SHADOW[i] only at the wrap edge (glitch-free update).
REQ-021 If a DUTY write to channel i coincides with the wrap edge, DUTY_ACTIVE[i] SHALL take wr_data directly.
REQ-022 Raw PWM level: p = (cnt < DUTY_ACTIVE[i]); DUTY_ACTIVE=0 gives constant 0; DUTY_ACTIVE=MAX gives constant 1.
REQ-023 Registered output: out[i] = 0 if OUT_EN=0; else (PWM_EN ? p : 1) XOR INVERT.
REQ-024 CTRL changes SHALL take effect on the next registered output, with no period alignment.
REQ-025 All channels SHALL share cnt, so rising edges are phase-aligned at cnt==0.

Reset
REQ-026 When rst_n=0 at a clock edge: out=0, rd_data=0, period_start=0, pcnt=0, cnt=0, PRESC=0, all DUTY_SHADOW/DUTY_ACTIVE=0, all CTRL=0.
REQ-027 Reset SHALL override a simultaneous write; reset mid-period SHALL abandon the period with no partial pulse on the following cycles.

Verification
REQ-028 Reset, then write CTRL[0]=0x1, DUTY[0]=0x80, wait one period -> out[0] constant 1 (OUT_EN with PWM_EN=0), and out[0] stays 0 before the CTRL write.
REQ-029 CNT_W=8, PRESC=0, CTRL[3]=0x3, DUTY[3]=0x80 -> out[3] high 128 cycles, low 127 cycles per 255-cycle period, starting at the first period_start after the write.
REQ-030 Mid-period write DUTY[3]=0x40 -> current period keeps width 128, next period has width 64; a DUTY write landing on the wrap edge takes effect in that same period.
REQ-031 DUTY=0 -> out constantly 0; DUTY=0xFF -> out constantly 1; INVERT=1 complements both cases.
REQ-032 PRESC=3 -> period_start every 4*255=1020 cycles; a PRESC write mid-period restarts pcnt; a write to address 2*NUM_CH+1 is ignored and reads 0.
REQ-033 Assert rst_n low mid-pulse with several channels active -> all outputs 0 on the next cycle and all registers read 0 afterwards.

Source files
------------

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator with a shared prescaled period counter,
// per-channel shadow/active duty registers and a small register file.
module pwm_multi_channel #(
  parameter int NUM_CH = 16,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = $clog2(2*NUM_CH+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CNT_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'((2**CNT_W) - 2);
  localparam logic [ADDR_W-1:0] PRESC_ADDR = ADDR_W'(2*NUM_CH);

  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] presc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] duty_shadow [NUM_CH];
  logic [CNT_W-1:0] duty_active [NUM_CH];
  logic [2:0]       ctrl        [NUM_CH];

  logic              tick;
  logic              wrap;
  logic              presc_we;
  logic [NUM_CH-1:0] duty_we;
  logic [NUM_CH-1:0] ctrl_we;
  logic [CNT_W-1:0]  cnt_n;
  logic [CNT_W-1:0]  active_n [NUM_CH];
  logic [2:0]        ctrl_n   [NUM_CH];
  logic [NUM_CH-1:0] out_n;
  logic [CNT_W-1:0]  rd_n;

  assign tick     = (pcnt == presc);
  assign wrap     = tick && (cnt == CNT_LAST);
  assign presc_we = wr_en && (wr_addr == PRESC_ADDR);

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    cnt_n = cnt;
    if (tick) cnt_n = wrap ? '0 : cnt + CNT_W'(1);
  end

  // The output register is fed from next-state values so out lines up with
  // cnt and period_start, and CTRL writes show on the very next output.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      duty_we[i]  = wr_en && (wr_addr == ADDR_W'(2*i));
      ctrl_we[i]  = wr_en && (wr_addr == ADDR_W'(2*i + 1));
      active_n[i] = duty_active[i];
      if (wrap) active_n[i] = duty_we[i] ? wr_data : duty_shadow[i];
      ctrl_n[i]   = ctrl_we[i] ? wr_data[2:0] : ctrl[i];
      out_n[i]    = ctrl_n[i][0] &
                    ((ctrl_n[i][1] ? (cnt_n < active_n[i]) : 1'b1) ^ ctrl_n[i][2]);
    end
  end

  always_comb begin
    rd_n = '0;
    if (rd_addr == PRESC_ADDR) rd_n = presc;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_addr == ADDR_W'(2*i))     rd_n = duty_shadow[i];
      if (rd_addr == ADDR_W'(2*i + 1)) rd_n = CNT_W'(ctrl[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt         <= '0;
      presc        <= '0;
      cnt          <= '0;
      out          <= '0;
      rd_data      <= '0;
      period_start <= 1'b0;
      // NOTE: these register arrays are architectural state that must read 0
      // after reset, so they are reset explicitly rather than left as RAM.
      for (int i = 0; i < NUM_CH; i++) begin
        duty_shadow[i] <= '0;
        duty_active[i] <= '0;
        ctrl[i]        <= '0;
      end
    end else begin
      pcnt         <= (presc_we || tick) ? '0 : pcnt + CNT_W'(1);
      if (presc_we) presc <= wr_data;
      cnt          <= cnt_n;
      out          <= out_n;
      rd_data      <= rd_n;
      period_start <= wrap;
      for (int i = 0; i < NUM_CH; i++) begin
        if (duty_we[i]) duty_shadow[i] <= wr_data;
        duty_active[i] <= active_n[i];
        ctrl[i]        <= ctrl_n[i];
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel: cycle-level reference model
// compared every cycle, plus directed period/width measurements.
module tb_pwm_multi_channel;

  localparam int NUM_CH = 16;
  localparam int CNT_W  = 8;
  localparam int ADDR_W = $clog2(2*NUM_CH+1);
  localparam int MAX    = (2**CNT_W) - 1;
  localparam int PRESC_A = 2*NUM_CH;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [CNT_W-1:0]  wr_data = '0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [CNT_W-1:0]  rd_data;
  logic [NUM_CH-1:0] out;
  logic              period_start;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pwm_multi_channel #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .out(out), .period_start(period_start)
  );

  // Reference model state, updated once per rising edge from the register rules.
  int m_presc, m_pcnt, m_cnt;
  int m_shadow [NUM_CH];
  int m_active [NUM_CH];
  int m_ctrl   [NUM_CH];
  logic [NUM_CH-1:0] m_out;
  logic              m_ps;
  logic [CNT_W-1:0]  m_rd;

  function automatic int reg_value(int a);
    if (a < 2*NUM_CH) return (a % 2 == 0) ? m_shadow[a/2] : m_ctrl[a/2];
    if (a == PRESC_A) return m_presc;
    return 0;
  endfunction

  function automatic logic model_level(int i);
    logic lvl;
    if ((m_ctrl[i] & 1) == 0) return 1'b0;
    lvl = ((m_ctrl[i] & 2) != 0) ? (m_cnt < m_active[i]) : 1'b1;
    return lvl ^ logic'((m_ctrl[i] >> 2) & 1);
  endfunction

  function automatic void model_clock();
    int  a;
    bit  tick, wrap;
    if (!rst_n) begin
      m_presc = 0; m_pcnt = 0; m_cnt = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_shadow[i] = 0; m_active[i] = 0; m_ctrl[i] = 0;
      end
      m_out = '0; m_ps = 1'b0; m_rd = '0;
      return;
    end
    m_rd = CNT_W'(reg_value(int'(rd_addr)));
    tick = (m_pcnt == m_presc);
    wrap = tick && (m_cnt == MAX - 1);
    m_pcnt = tick ? 0 : m_pcnt + 1;
    if (tick) m_cnt = (m_cnt + 1) % MAX;
    if (wr_en) begin
      a = int'(wr_addr);
      if (a < 2*NUM_CH) begin
        if (a % 2 == 0) m_shadow[a/2] = int'(wr_data);
        else            m_ctrl[a/2]   = int'(wr_data) & 7;
      end else if (a == PRESC_A) begin
        m_presc = int'(wr_data);
        m_pcnt  = 0;
      end
    end
    if (wrap) for (int i = 0; i < NUM_CH; i++) m_active[i] = m_shadow[i];
    m_ps = wrap;
    for (int i = 0; i < NUM_CH; i++) m_out[i] = model_level(i);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check("out", 32'(out), 32'(m_out));
    check("period_start", 32'(period_start), 32'(m_ps));
    check("rd_data", 32'(rd_data), 32'(m_rd));
    rd_addr = ADDR_W'($urandom_range(0, 2**ADDR_W - 1));
  endtask

  task automatic write_reg(input int a, input int d);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = CNT_W'(d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic read_chk(input string tag, input int a, input int exp);
    rd_addr = ADDR_W'(a);
    step();
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic wait_ps(input int max_cycles);
    for (int n = 0; n < max_cycles; n++) begin
      step();
      if (period_start === 1'b1) break;
    end
    check("wait_ps", 32'(period_start), 32'd1);
  endtask

  task automatic measure(input int ch, input int n, output int highs);
    highs = int'(out[ch]);
    for (int k = 1; k < n; k++) begin
      step();
      highs += int'(out[ch]);
    end
  endtask

  task automatic dist_to_ps(input int start, output int n);
    n = start;
    do begin
      step();
      n++;
    end while (period_start !== 1'b1 && n < 1200);
  endtask

  initial begin
    int h;
    int hs [4];
    int n;
    int a;

    // Reset state
    repeat (3) step();
    rst_n = 1'b1;
    check("rst_out", 32'(out), 32'd0);
    check("rst_ps", 32'(period_start), 32'd0);
    check("rst_rd", 32'(rd_data), 32'd0);
    repeat (5) step();
    check("out0_pre", 32'(out[0]), 32'd0);

    // Channel 0: OUT_EN only gives constant 1
    write_reg(1, 8'h01);
    write_reg(0, 8'h80);
    wait_ps(600);
    measure(0, 255, h);
    check("out0_const1", 32'(h), 32'd255);

    // Channel 3: 128-high / 127-low, period 255
    write_reg(7, 8'h03);
    write_reg(6, 8'h80);
    wait_ps(600);
    measure(3, 255, h);
    check("width_128", 32'(h), 32'd128);
    step();
    check("period_255", 32'(period_start), 32'd1);

    // Mid-period duty write keeps the current width
    h = int'(out[3]);
    for (int k = 1; k < 255; k++) begin
      if (k == 10) begin
        wr_en = 1'b1; wr_addr = ADDR_W'(6); wr_data = 8'h40;
      end
      step();
      wr_en = 1'b0;
      h += int'(out[3]);
    end
    check("width_keep", 32'(h), 32'd128);
    step();
    check("ps_next", 32'(period_start), 32'd1);
    measure(3, 255, h);
    check("width_64", 32'(h), 32'd64);
    // Write landing exactly on the wrap edge
    write_reg(6, 8'h20);
    check("wrap_ps", 32'(period_start), 32'd1);
    measure(3, 255, h);
    check("width_wrap_32", 32'(h), 32'd32);

    // Duty extremes with and without INVERT
    write_reg(10, 8'h00); write_reg(11, 8'h03);
    write_reg(12, 8'hFF); write_reg(13, 8'h03);
    write_reg(14, 8'h00); write_reg(15, 8'h07);
    write_reg(16, 8'hFF); write_reg(17, 8'h07);
    wait_ps(600);
    for (int c = 0; c < 4; c++) hs[c] = int'(out[5+c]);
    for (int k = 1; k < 255; k++) begin
      step();
      for (int c = 0; c < 4; c++) hs[c] += int'(out[5+c]);
    end
    check("duty0", 32'(hs[0]), 32'd0);
    check("dutyff", 32'(hs[1]), 32'd255);
    check("duty0_inv", 32'(hs[2]), 32'd255);
    check("dutyff_inv", 32'(hs[3]), 32'd0);

    // Randomized register traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        a = int'($urandom_range(0, 2**ADDR_W - 1));
        write_reg(a, (a == PRESC_A) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, MAX)));
      end else begin
        step();
      end
    end

    // Prescaler
    write_reg(PRESC_A, 3);
    wait_ps(1100);
    dist_to_ps(0, n);
    check("presc_period", 32'(n), 32'd1020);
    step();
    step();
    write_reg(PRESC_A, 3);
    dist_to_ps(3, n);
    check("presc_restart", 32'(n), 32'd1023);
    write_reg(PRESC_A + 1, 8'h55);
    read_chk("rd_unmapped", PRESC_A + 1, 0);
    read_chk("rd_presc", PRESC_A, 3);

    // Reset mid-pulse with a simultaneous write
    write_reg(6, 8'h80);
    write_reg(7, 8'h03);
    write_reg(1, 8'h01);
    write_reg(13, 8'h01);
    wait_ps(1100);
    repeat (5) step();
    check("pulse_on", 32'(out[3]), 32'd1);
    rst_n = 1'b0;
    wr_en = 1'b1; wr_addr = ADDR_W'(1); wr_data = 8'h07;
    step();
    wr_en = 1'b0;
    rst_n = 1'b1;
    check("rst_mid_out", 32'(out), 32'd0);
    repeat (20) step();
    check("rst_stay_out", 32'(out), 32'd0);
    for (int r = 0; r <= PRESC_A; r++) read_chk("rd_after_rst", r, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
